// File: rtl/mux32_sel_reg.sv
// mux32_sel_reg: N-way, WIDTH-bit word selector with a 5-bit index.
// y is the combinational pick. y_q/y_valid hold a registered copy for
// timing-critical consumers. Out-of-range indices select zero and raise sel_err.
module mux32_sel_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SEL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     y_q,
  output logic                 y_valid,
  output logic                 sel_err
);

  // N may equal 2**SEL_W, so the bound needs one extra bit. The select is
  // zero-extended to match it.
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic [WIDTH-1:0] entry [N];
  logic             in_range;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] cap_q,   cap_d;
  logic             valid_q, valid_d;

  // Unpack the flattened bus into one word per entry.
  for (genvar g = 0; g < N; g++) begin : g_entry
    assign entry[g] = data_in[g*WIDTH +: WIDTH];
  end

  // Range check against N, using the zero-extended select.
  assign in_range = ({1'b0, sel} < N_EXT);

  // AND-OR selection. At most one index matches, so the order of the loop
  // does not matter and no priority is implied.
  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        pick = pick | entry[i];
      end
    end
  end

  assign y       = in_range ? pick : '0;
  assign sel_err = ~in_range;

  // Next-state for the capture register. When en is high it loads whatever y
  // shows, including the zero for an out-of-range select.
  always_comb begin
    cap_d   = cap_q;
    valid_d = valid_q;
    if (en) begin
      cap_d   = y;
      valid_d = 1'b1;
    end
  end

  // Capture register. Reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      valid_q <= valid_d;
    end
  end

  assign y_q     = cap_q;
  assign y_valid = valid_q;

endmodule

// File: tb/tb_mux32_sel_reg.sv
// Bench for mux32_sel_reg. It runs a full-size build (N=32) next to a reduced
// build (N=20) and compares both against a word-array reference model.
module tb_mux32_sel_reg;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1023:0] data32;
  logic [639:0]  data20;
  logic [4:0]    sel32, sel20;
  logic [31:0]   y32, yq32, y20, yq20;
  logic          v32, v20, err32, err20;

  int total = 0;
  int bad   = 0;

  logic [31:0] ent [32];
  logic [31:0] exp_q32, exp_q20;
  logic        exp_v32, exp_v20;

  mux32_sel_reg u_dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data32), .sel(sel32),
    .y(y32), .y_q(yq32), .y_valid(v32), .sel_err(err32)
  );

  mux32_sel_reg #(.WIDTH(32), .N(20), .SEL_W(5)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data20), .sel(sel20),
    .y(y20), .y_q(yq20), .y_valid(v20), .sel_err(err20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < 32; i++) data32[i*32 +: 32] = ent[i];
    data20 = data32[639:0];
  endtask

  function automatic logic [31:0] ref_y(input int n, input logic [4:0] s);
    return (int'(s) < n) ? ent[s] : 32'h0;
  endfunction

  task automatic chk_comb(input string tag);
    chk({tag, " y32"},   y32,   ref_y(32, sel32));
    chk({tag, " err32"}, {31'b0, err32}, 32'h0);
    chk({tag, " y20"},   y20,   ref_y(20, sel20));
    chk({tag, " err20"}, {31'b0, err20}, (int'(sel20) >= 20) ? 32'h1 : 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sel32 = '0;
    sel20 = '0;
    for (int i = 0; i < 32; i++) ent[i] = 32'(i);
    pack();
    #1;
    chk("reset yq32", yq32, 32'h0);
    chk("reset v32",  {31'b0, v32}, 32'h0);
    chk("reset yq20", yq20, 32'h0);
    chk("reset v20",  {31'b0, v20}, 32'h0);

    // Identity sweep, 10 time units per step.
    for (int s = 0; s < 32; s++) begin
      sel32 = 5'(s);
      sel20 = 5'(s);
      #10;
      chk("sweep y32", y32, 32'(s));
      chk_comb("sweep");
    end

    // Pattern check, including a data change with no clock.
    for (int i = 0; i < 32; i++) ent[i] = 32'hA5A5_0000 | 32'(i);
    pack();
    sel32 = 5'd17;
    #1;
    chk("pattern y", y32, 32'hA5A5_0011);
    ent[17] = 32'hFFFF_FFFF;
    pack();
    #1;
    chk("pattern follow", y32, 32'hFFFF_FFFF);

    // Registered path.
    for (int i = 0; i < 32; i++) ent[i] = 32'(i);
    pack();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    en    = 1'b1;
    sel32 = 5'd5;
    sel20 = 5'd5;
    @(posedge clk);
    #1;
    chk("reg yq32", yq32, 32'd5);
    chk("reg v32",  {31'b0, v32}, 32'h1);
    chk("reg yq20", yq20, 32'd5);
    @(negedge clk);
    en    = 1'b0;
    sel32 = 5'd9;
    sel20 = 5'd9;
    #1;
    chk("hold y", y32, 32'd9);
    repeat (3) @(posedge clk);
    #1;
    chk("hold yq32", yq32, 32'd5);
    chk("hold v32",  {31'b0, v32}, 32'h1);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst yq32", yq32, 32'h0);
    chk("arst v32",  {31'b0, v32}, 32'h0);
    chk("arst y32",  y32, 32'd9);
    chk("arst yq20", yq20, 32'h0);
    rst_n = 1'b1;

    // Out-of-range select on the N=20 build. Load 7 first so that the later
    // capture of 0 is visible.
    @(negedge clk);
    en    = 1'b1;
    sel20 = 5'd7;
    @(posedge clk);
    #1;
    chk("oor pre yq20", yq20, 32'd7);
    @(negedge clk);
    sel20 = 5'd25;
    #1;
    chk("oor y20",   y20, 32'h0);
    chk("oor err20", {31'b0, err20}, 32'h1);
    @(posedge clk);
    #1;
    chk("oor yq20", yq20, 32'h0);
    chk("oor v20",  {31'b0, v20}, 32'h1);
    @(negedge clk);
    sel20 = 5'd19;
    #1;
    chk("edge y20",   y20, 32'd19);
    chk("edge err20", {31'b0, err20}, 32'h0);

    // Randomized traffic checked against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    exp_q32 = '0; exp_v32 = 1'b0;
    exp_q20 = '0; exp_v20 = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      for (int i = 0; i < 32; i++) ent[i] = $urandom;
      pack();
      sel32 = 5'($urandom_range(0, 31));
      sel20 = 5'($urandom_range(0, 31));
      en    = ($urandom_range(0, 3) != 0);
      #1;
      chk_comb("rand");
      if (en) begin
        exp_q32 = ref_y(32, sel32); exp_v32 = 1'b1;
        exp_q20 = ref_y(20, sel20); exp_v20 = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("rand yq32", yq32, exp_q32);
      chk("rand v32",  {31'b0, v32}, {31'b0, exp_v32});
      chk("rand yq20", yq20, exp_q20);
      chk("rand v20",  {31'b0, v20}, {31'b0, exp_v20});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux32_sel_reg.md
Name: mux32_sel_reg

Overview:
- Parameterised N-way, WIDTH-bit selector with a 5-bit select, used as a one-hot-free word picker in the datapath (register-file read port, operand select).
- Provides a combinational output and a registered copy with a valid flag for timing-critical consumers.
- Default configuration: 32 entries of 32 bits.

Parameters:
- WIDTH, 32, bit width of each input entry and of the outputs.
- N, 32, number of input entries (1..2**SEL_W).
- SEL_W, 5, select width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  capture enable for the registered output.
- data_in  input  N*WIDTH  flattened entries; entry i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the entry to forward.
- y  output  WIDTH  combinational selected entry.
- y_q  output  WIDTH  registered selected entry.
- y_valid  output  1  high once y_q holds a captured value.
- sel_err  output  1  combinational flag: sel >= N.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- y = entry[sel] when sel < N, purely combinational, zero cycles latency.
  - Must settle within one evaluation after any change of data_in or sel.
  - No clock dependence.
- sel >= N (only possible when N < 2**SEL_W):
  - y = 0.
  - sel_err = 1.
  - Otherwise sel_err = 0.
- No X-propagation shortcuts: X or Z on sel is not a supported input.
  - Bench must drive known values.
- Registered path:
  - On rising clk with en = 1: y_q <= y (including the 0 for out-of-range sel), and y_valid <= 1.
  - en = 0: y_q and y_valid hold.
- Reset: rst_n low asynchronously forces y_q = 0 and y_valid = 0, regardless of clk or en.
  - Release is synchronous in effect: the first capture occurs on the first rising clk with rst_n = 1 and en = 1.
- Reset asserted mid-operation:
  - y_q and y_valid clear immediately.
  - The combinational y is unaffected by reset and keeps tracking sel and data_in.
- Simultaneous sel change and clock edge: y_q captures the value of y present before the edge (standard setup semantics).
- Width rules:
  - sel is zero-extended for comparison against N.
  - No truncation of entries; entry values are forwarded bit-exact.
- Implementation is a plain indexed selection or an explicit case.
  - No priority chain that alters results.
  - Generate-based parameterisation is required so that any N/WIDTH within the stated range elaborates.

Test Plan:
- Identity sweep:
  - Stimulus: entry i = i for i = 0..31; sel stepped 0..31, 10 time units apart.
  - Response: y = sel each step (y = 0 at sel = 0, y = 31 at sel = 31); sel_err = 0 throughout.
- Pattern check:
  - Stimulus: entry i = 32'hA5A5_0000 | i; sel = 17.
  - Response: y = 32'hA5A5_0011.
  - Stimulus: then data_in entry 17 changed to 32'hFFFF_FFFF with sel held.
  - Response: y follows without a clock.
- Registered path:
  - Stimulus: rst_n pulsed low, then high; en = 1; sel = 5 with entries = index.
  - Response: after the first rising clk, y_q = 5 and y_valid = 1.
  - Stimulus: then en = 0 and sel = 9.
  - Response: y = 9 immediately, while y_q stays 5 across several clocks.
- Asynchronous reset:
  - Stimulus: with y_q = 5 and y_valid = 1, drop rst_n between clock edges.
  - Response: y_q = 0 and y_valid = 0 immediately, while y continues to show entry[sel].
- Out-of-range (N = 20 build):
  - Stimulus: sel = 25.
  - Response: y = 0, sel_err = 1; with en = 1, y_q = 0 after the next clk.
  - Stimulus: sel = 19.
  - Response: y = entry 19, sel_err = 0.
